kb_edit_ctrl: RTL and testbench

KB_EDIT_CTRL -- requirements
Module: kb_edit_ctrl

---
 rtl/kb_edit_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_kb_edit_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/kb_edit_ctrl.sv
// PS/2 keyboard edit controller: turns scan-code bytes into BCD field edits and commits.
// Optional inactivity timeout enabled by defining KBEDIT_TIMEOUT_EN.
module kb_edit_ctrl #(
    parameter int unsigned DIGITS         = 2,
    parameter int unsigned GROUP_SIZE     = 3,
    parameter logic [7:0]  CLOCK_BASE     = 8'd0,
    parameter logic [7:0]  DATE_BASE      = 8'd3,
    parameter logic [7:0]  TIMER_BASE     = 8'd6,
    parameter logic [7:0]  RING_ADDR      = 8'd10,
    parameter logic [7:0]  TOGGLE_ADDR    = 8'd11,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [7:0]            scan_code,
    input  logic                  scan_valid,
    input  logic                  commit_ack,
    output logic [7:0]            address,
    output logic [4*DIGITS-1:0]   data,
    output logic                  commit_valid,
    output logic                  edit_active,
    output logic [2:0]            field_idx
);

    localparam int unsigned DW = 4 * DIGITS;

    localparam logic [7:0] CodeBrk   = 8'hF0;
    localparam logic [7:0] CodeExt   = 8'hE0;
    localparam logic [7:0] CodeF1    = 8'h05;
    localparam logic [7:0] CodeF2    = 8'h06;
    localparam logic [7:0] CodeF3    = 8'h04;
    localparam logic [7:0] CodeTab   = 8'h0D;
    localparam logic [7:0] CodeEnter = 8'h5A;
    localparam logic [7:0] CodeF11   = 8'h78;
    localparam logic [7:0] CodeF12   = 8'h07;
    localparam logic [7:0] CodeEsc   = 8'h76;

    localparam logic [2:0] LastIdx = 3'(GROUP_SIZE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StEdit,
        StCommit
    } state_e;

    state_e          state_q, state_d;
    logic            brk_q, brk_d;
    logic            ext_q, ext_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      base_q, base_d;
    logic [DW-1:0]   data_q, data_d;
    logic [2:0]      idx_q, idx_d;

    logic            is_digit;
    logic [3:0]      digit;
    logic            to_idle;

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        unique case (scan_code)
            8'h45:   digit = 4'd0;
            8'h16:   digit = 4'd1;
            8'h1E:   digit = 4'd2;
            8'h26:   digit = 4'd3;
            8'h25:   digit = 4'd4;
            8'h2E:   digit = 4'd5;
            8'h36:   digit = 4'd6;
            8'h3D:   digit = 4'd7;
            8'h3E:   digit = 4'd8;
            8'h46:   digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

`ifdef KBEDIT_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_hit;

    assign tmo_hit = (state_q == StEdit) && (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1);
`endif

    always_comb begin
        state_d = state_q;
        brk_d   = brk_q;
        ext_d   = ext_q;
        addr_d  = addr_q;
        base_d  = base_q;
        data_d  = data_q;
        idx_d   = idx_q;
        to_idle = 1'b0;

        if (state_q == StCommit) begin
            // Bytes arriving while a commit is pending are dropped; prefixes keep their value.
            if (commit_ack) begin
                to_idle = 1'b1;
            end
        end else if (scan_valid) begin
            if (brk_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (scan_code == CodeEsc && state_q == StEdit) begin
                    to_idle = 1'b1;
                end
            end else if (scan_code == CodeBrk) begin
                brk_d = 1'b1;
            end else if (scan_code == CodeExt) begin
                ext_d = 1'b1;
            end else if (ext_q) begin
                ext_d = 1'b0;
            end else if (is_digit) begin
                if (state_q == StEdit) begin
                    data_d = DW'({data_q, digit});
                end
            end else begin
                unique case (scan_code)
                    CodeF1, CodeF2, CodeF3: begin
                        state_d = StEdit;
                        base_d  = (scan_code == CodeF1) ? DATE_BASE :
                                  (scan_code == CodeF2) ? CLOCK_BASE : TIMER_BASE;
                        addr_d  = base_d;
                        idx_d   = 3'd0;
                        data_d  = '0;
                    end
                    CodeTab: begin
                        if (state_q == StEdit) begin
                            data_d = '0;
                            if (idx_q == LastIdx) begin
                                idx_d  = 3'd0;
                                addr_d = base_q;
                            end else begin
                                idx_d  = idx_q + 3'd1;
                                addr_d = addr_q + 8'd1;
                            end
                        end
                    end
                    CodeEnter: begin
                        if (state_q == StEdit) begin
                            state_d = StCommit;
                        end
                    end
                    CodeF11: begin
                        state_d = StCommit;
                        addr_d  = TOGGLE_ADDR;
                        data_d  = DW'(1);
                    end
                    CodeF12: begin
                        state_d = StCommit;
                        addr_d  = RING_ADDR;
                        data_d  = '0;
                    end
                    CodeEsc: begin
                        if (state_q == StEdit) begin
                            to_idle = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
`ifdef KBEDIT_TIMEOUT_EN
        else if (tmo_hit) begin
            to_idle = 1'b1;
        end
`endif

        if (to_idle) begin
            state_d = StIdle;
            addr_d  = 8'd0;
            data_d  = '0;
            idx_d   = 3'd0;
        end
    end

`ifdef KBEDIT_TIMEOUT_EN
    // Counts only while editing; any accepted byte or a fresh EDIT entry restarts it.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        if ((scan_valid && state_q != StCommit) || state_q != StEdit || state_d != StEdit) begin
            tmo_cnt_d = 32'd0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tmo_cnt_q <= 32'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            addr_q  <= 8'd0;
            base_q  <= 8'd0;
            data_q  <= '0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    assign address      = addr_q;
    assign data         = data_q;
    assign field_idx    = idx_q;
    assign commit_valid = (state_q == StCommit);
    assign edit_active  = (state_q == StEdit);

endmodule

// File: tb/tb_kb_edit_ctrl.sv
// Scoreboard bench for kb_edit_ctrl: each driven cycle pushes the expected outputs,
// which are popped and compared after the clock edge.
module tb_kb_edit_ctrl;

`ifdef KBEDIT_TIMEOUT_EN
    localparam logic [31:0] TO = 32'd16;
`else
    localparam logic [31:0] TO = 32'd500_000_000;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic       commit_ack = 1'b0;
    logic [7:0] address;
    logic [7:0] data;
    logic       commit_valid;
    logic       edit_active;
    logic [2:0] field_idx;

    int checks = 0;
    int passes = 0;

    typedef struct {
        string      tag;
        logic [7:0] addr;
        logic [7:0] dat;
        logic       cv;
        logic       ea;
        logic [2:0] idx;
    } exp_t;

    exp_t sb[$];

    kb_edit_ctrl #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .commit_ack  (commit_ack),
        .address     (address),
        .data        (data),
        .commit_valid(commit_valid),
        .edit_active (edit_active),
        .field_idx   (field_idx)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic compare_outputs(input exp_t e);
        check_eq({e.tag, ".addr"}, 32'(address), 32'(e.addr));
        check_eq({e.tag, ".data"}, 32'(data), 32'(e.dat));
        check_eq({e.tag, ".cv"}, 32'(commit_valid), 32'(e.cv));
        check_eq({e.tag, ".ea"}, 32'(edit_active), 32'(e.ea));
        check_eq({e.tag, ".idx"}, 32'(field_idx), 32'(e.idx));
    endtask

    // Drive one clock cycle of input, then pop and compare the expected post-edge outputs.
    task automatic cyc(input string tag, input logic v, input logic [7:0] code, input logic ack,
                       input logic [7:0] ea_addr, input logic [7:0] e_dat, input logic e_cv,
                       input logic e_ea, input logic [2:0] e_idx);
        exp_t e;
        e.tag = tag; e.addr = ea_addr; e.dat = e_dat; e.cv = e_cv; e.ea = e_ea; e.idx = e_idx;
        sb.push_back(e);
        scan_valid = v;
        scan_code  = code;
        commit_ack = ack;
        @(posedge CLK);
        #1;
        scan_valid = 1'b0;
        commit_ack = 1'b0;
        if (sb.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            compare_outputs(sb.pop_front());
        end
    endtask

    initial begin
        exp_t z;
        z.tag = "reset"; z.addr = 8'h00; z.dat = 8'h00; z.cv = 1'b0; z.ea = 1'b0; z.idx = 3'd0;
        #2;
        compare_outputs(z);
        @(negedge CLK);
        RESET = 1'b0;

        // F2, digits 1 and 2, Enter, ack
        cyc("f2",     1, 8'h06, 0, 8'd0, 8'h00, 0, 1, 3'd0);
        cyc("d1",     1, 8'h16, 0, 8'd0, 8'h01, 0, 1, 3'd0);
        cyc("d2",     1, 8'h1E, 0, 8'd0, 8'h12, 0, 1, 3'd0);
        cyc("enter",  1, 8'h5A, 0, 8'd0, 8'h12, 1, 0, 3'd0);
        cyc("ack",    0, 8'h00, 1, 8'd0, 8'h00, 0, 0, 3'd0);

        // F1 group walk with Tab wrap; data cleared on each Tab
        cyc("f1",     1, 8'h05, 0, 8'd3, 8'h00, 0, 1, 3'd0);
        cyc("d7",     1, 8'h3D, 0, 8'd3, 8'h07, 0, 1, 3'd0);
        cyc("tab1",   1, 8'h0D, 0, 8'd4, 8'h00, 0, 1, 3'd1);
        cyc("d9",     1, 8'h46, 0, 8'd4, 8'h09, 0, 1, 3'd1);
        cyc("tab2",   1, 8'h0D, 0, 8'd5, 8'h00, 0, 1, 3'd2);
        cyc("tab3",   1, 8'h0D, 0, 8'd3, 8'h00, 0, 1, 3'd0);

        // Release and extended codes discarded; unlisted make ignored
        cyc("d5",     1, 8'h2E, 0, 8'd3, 8'h05, 0, 1, 3'd0);
        cyc("brk",    1, 8'hF0, 0, 8'd3, 8'h05, 0, 1, 3'd0);
        cyc("rel1",   1, 8'h16, 0, 8'd3, 8'h05, 0, 1, 3'd0);
        cyc("ext",    1, 8'hE0, 0, 8'd3, 8'h05, 0, 1, 3'd0);
        cyc("ext0",   1, 8'h45, 0, 8'd3, 8'h05, 0, 1, 3'd0);
        cyc("unlist", 1, 8'h1C, 0, 8'd3, 8'h05, 0, 1, 3'd0);
        cyc("d3",     1, 8'h26, 0, 8'd3, 8'h53, 0, 1, 3'd0);
        cyc("esc",    1, 8'h76, 0, 8'd0, 8'h00, 0, 0, 3'd0);

        // Idle ignores digits, Enter and a stray ack
        cyc("idl_d",  1, 8'h16, 0, 8'd0, 8'h00, 0, 0, 3'd0);
        cyc("idl_en", 1, 8'h5A, 0, 8'd0, 8'h00, 0, 0, 3'd0);
        cyc("idl_ak", 0, 8'h00, 1, 8'd0, 8'h00, 0, 0, 3'd0);

        // Esc release also leaves EDIT; top digit drops on overflow; F12 from EDIT
        cyc("f3",     1, 8'h04, 0, 8'd6, 8'h00, 0, 1, 3'd0);
        cyc("f3d1",   1, 8'h16, 0, 8'd6, 8'h01, 0, 1, 3'd0);
        cyc("f3brk",  1, 8'hF0, 0, 8'd6, 8'h01, 0, 1, 3'd0);
        cyc("escrel", 1, 8'h76, 0, 8'd0, 8'h00, 0, 0, 3'd0);
        cyc("f3b",    1, 8'h04, 0, 8'd6, 8'h00, 0, 1, 3'd0);
        cyc("s1",     1, 8'h16, 0, 8'd6, 8'h01, 0, 1, 3'd0);
        cyc("s2",     1, 8'h1E, 0, 8'd6, 8'h12, 0, 1, 3'd0);
        cyc("s3",     1, 8'h26, 0, 8'd6, 8'h23, 0, 1, 3'd0);
        cyc("f12",    1, 8'h07, 0, 8'd10, 8'h00, 1, 0, 3'd0);
        cyc("f12ack", 0, 8'h00, 1, 8'd0, 8'h00, 0, 0, 3'd0);

        // F11 pending: byte dropped, ack beats a simultaneous byte
        cyc("f11",    1, 8'h78, 0, 8'd11, 8'h01, 1, 0, 3'd0);
        cyc("pend05", 1, 8'h05, 0, 8'd11, 8'h01, 1, 0, 3'd0);
        cyc("ackbyt", 1, 8'h05, 1, 8'd0, 8'h00, 0, 0, 3'd0);
        cyc("lost",   0, 8'h00, 0, 8'd0, 8'h00, 0, 0, 3'd0);

        // F0 during a commit must not arm a release prefix
        cyc("f11b",   1, 8'h78, 0, 8'd11, 8'h01, 1, 0, 3'd0);
        cyc("cm_brk", 1, 8'hF0, 0, 8'd11, 8'h01, 1, 0, 3'd0);
        cyc("ack2",   0, 8'h00, 1, 8'd0, 8'h00, 0, 0, 3'd0);
        cyc("f1post", 1, 8'h05, 0, 8'd3, 8'h00, 0, 1, 3'd0);
        cyc("escp",   1, 8'h76, 0, 8'd0, 8'h00, 0, 0, 3'd0);

`ifdef KBEDIT_TIMEOUT_EN
        cyc("to_f3",  1, 8'h04, 0, 8'd6, 8'h00, 0, 1, 3'd0);
        for (int i = 0; i < 15; i++) cyc("to_wait", 0, 8'h00, 0, 8'd6, 8'h00, 0, 1, 3'd0);
        cyc("to_hit", 0, 8'h00, 0, 8'd0, 8'h00, 0, 0, 3'd0);
        cyc("rs_f3",  1, 8'h04, 0, 8'd6, 8'h00, 0, 1, 3'd0);
        for (int i = 0; i < 9; i++) cyc("rs_wait", 0, 8'h00, 0, 8'd6, 8'h00, 0, 1, 3'd0);
        cyc("rs_key", 1, 8'h16, 0, 8'd6, 8'h01, 0, 1, 3'd0);
        for (int i = 0; i < 15; i++) cyc("rs_hold", 0, 8'h00, 0, 8'd6, 8'h01, 0, 1, 3'd0);
        cyc("rs_hit", 0, 8'h00, 0, 8'd0, 8'h00, 0, 0, 3'd0);
`endif

        // Asynchronous reset in the middle of a commit
        cyc("f12r",   1, 8'h07, 0, 8'd10, 8'h00, 1, 0, 3'd0);
        #2;
        RESET = 1'b1;
        #1;
        z.tag = "async_rst";
        compare_outputs(z);
        @(negedge CLK);
        RESET = 1'b0;
        cyc("postrst", 0, 8'h00, 0, 8'd0, 8'h00, 0, 0, 3'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

endmodule
